bypass_sb: RTL and testbench

- Parametrised successor to the decode-stage register-file/bypass unit.
- Integrates the regfile (NWR=2 write ports: pipeline WB and long-latency WB) with NRD read ports.
- Forwards EX/MEM/WB/long-WB results to decode and generates the load-use interlock with store-data exemption.
- Adds a per-register scoreboard for multi-cycle ops (mul/div) and saturating stall counters for perf monitoring.

---
 rtl/bypass_sb.sv | 118 +++++++++++
 tb/tb_bypass_sb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_sb.sv
// bypass_sb: decode-stage register file, operand forwarding, load-use interlock,
// long-latency scoreboard and saturating stall counters.
//   i_clk/i_rst            clock, asynchronous active-high reset
//   i_flush                squashes the pipeline WB register-file write
//   i_rsid/i_rsren         decode source indices (port k at [k*AW+:AW]) and read enables
//   i_idu_*                decode destination, store and long-op issue flags
//   i_ex_*/i_mem_*/i_wb_*  pipeline stage status and results used for forwarding
//   i_lng_*                long-latency writeback and cancellation
//   i_ex_ldstbp/i_ex_rs2   EX late store-data bypass flag and store data
//   i_cnt_clr              synchronous clear of the stall counters
//   o_rs                   forwarded source values (port k at [k*XLEN+:XLEN])
//   o_ldstbp/o_ex_rs2      load->store-data late bypass request and resulting store data
//   o_stall                stall IF/ID and insert an ID/EX bubble
//   o_sb_pend              scoreboard pending bits
//   o_ldu_cnt/o_sb_cnt     load-use and scoreboard stall-cycle counters
module bypass_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int CNTW = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic [NRD*AW-1:0] i_rsid,
  input  logic [NRD-1:0]    i_rsren,
  input  logic [AW-1:0]     i_idu_rdid,
  input  logic              i_idu_rdwen,
  input  logic              i_idu_sten,
  input  logic              i_idu_lng,
  input  logic              i_ex_valid,
  input  logic              i_ex_rdwen,
  input  logic              i_ex_lden,
  input  logic [AW-1:0]     i_ex_rdid,
  input  logic [XLEN-1:0]   i_ex_res,
  input  logic              i_mem_valid,
  input  logic              i_mem_rdwen,
  input  logic              i_mem_lden,
  input  logic [AW-1:0]     i_mem_rdid,
  input  logic [XLEN-1:0]   i_mem_exres,
  input  logic [XLEN-1:0]   i_mem_lsres,
  input  logic              i_wb_valid,
  input  logic              i_wb_ready,
  input  logic              i_wb_rdwen,
  input  logic [AW-1:0]     i_wb_rdid,
  input  logic [XLEN-1:0]   i_wb_rd,
  input  logic              i_lng_wen,
  input  logic [AW-1:0]     i_lng_rdid,
  input  logic [XLEN-1:0]   i_lng_rd,
  input  logic              i_lng_kill,
  input  logic [AW-1:0]     i_lng_killid,
  input  logic              i_ex_ldstbp,
  input  logic [XLEN-1:0]   i_ex_rs2,
  input  logic              i_cnt_clr,
  output logic [NRD*XLEN-1:0] o_rs,
  output logic              o_ldstbp,
  output logic [XLEN-1:0]   o_ex_rs2,
  output logic              o_stall,
  output logic [NREG-1:0]   o_sb_pend,
  output logic [CNTW-1:0]   o_ldu_cnt,
  output logic [CNTW-1:0]   o_sb_cnt
);
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] pend, clr, set, pend_eff;
  logic [NRD-1:0]  ldm, sbm;
  logic            wa, ldex, only_st, ldu, sb_stall;

  assign wa = i_wb_rdwen & i_wb_valid & i_wb_ready & ~i_flush;

  genvar k;
  for (k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] id;
    assign id = i_rsid[k*AW +: AW];
    // Youngest producer wins; index 0 short-circuits so zero-rdid hits never forward.
    assign o_rs[k*XLEN +: XLEN] =
      (id == '0) ? '0 :
      (i_ex_valid & i_ex_rdwen & ~i_ex_lden & (i_ex_rdid == id)) ? i_ex_res :
      (i_mem_valid & i_mem_rdwen & (i_mem_rdid == id)) ? (i_mem_lden ? i_mem_lsres : i_mem_exres) :
      (i_lng_wen & (i_lng_rdid == id)) ? i_lng_rd :
      (i_wb_valid & i_wb_rdwen & (i_wb_rdid == id)) ? i_wb_rd : rf[id];
    assign ldm[k] = i_rsren[k] & (id == i_ex_rdid);
    assign sbm[k] = i_rsren[k] & pend_eff[id];
  end

  assign ldex     = i_ex_valid & i_ex_lden & i_ex_rdwen & (i_ex_rdid != '0);
  // A store whose only dependence is its data operand can take the load result late in EX.
  assign only_st  = i_idu_sten & (ldm == NRD'(2));
  assign ldu      = ldex & (|ldm) & ~only_st;
  assign o_ldstbp = ldex & only_st;
  assign o_ex_rs2 = i_ex_ldstbp ? o_rs[XLEN +: XLEN] : i_ex_rs2;

  // Completing or cancelled long ops release their register in the same cycle.
  assign clr      = ({NREG{i_lng_wen}} & (NREG'(1) << i_lng_rdid)) |
                    ({NREG{i_lng_kill}} & (NREG'(1) << i_lng_killid));
  assign pend_eff = pend & ~clr;
  assign sb_stall = (|sbm) | (i_idu_rdwen & pend_eff[i_idu_rdid]);
  assign o_stall  = ldu | sb_stall;
  assign set      = (i_idu_lng & i_idu_rdwen & ~o_stall & (i_idu_rdid != '0)) ?
                    NREG'(1) << i_idu_rdid : '0;
  assign o_sb_pend = pend;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend      <= '0;
      o_ldu_cnt <= '0;
      o_sb_cnt  <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      pend      <= pend_eff | set;
      o_ldu_cnt <= i_cnt_clr ? '0 : o_ldu_cnt + CNTW'(ldu & ~&o_ldu_cnt);
      o_sb_cnt  <= i_cnt_clr ? '0 : o_sb_cnt + CNTW'(sb_stall & ~ldu & ~&o_sb_cnt);
      if (wa && i_wb_rdid != '0) rf[i_wb_rdid] <= i_wb_rd;
      // Later assignment lets the long-latency port win an index collision.
      if (i_lng_wen && i_lng_rdid != '0) rf[i_lng_rdid] <= i_lng_rd;
    end
  end
endmodule

// File: tb/tb_bypass_sb.sv
// tb_bypass_sb: table, directed and randomized checks of bypass_sb against a reference model.
module tb_bypass_sb;
  localparam int XLEN = 64, NREG = 32, AW = 5, NRD = 2, CNTW = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0, rst = 1'b1;
  logic i_flush, i_idu_rdwen, i_idu_sten, i_idu_lng;
  logic [NRD*AW-1:0] i_rsid;
  logic [NRD-1:0] i_rsren;
  logic [AW-1:0] i_idu_rdid, i_ex_rdid, i_mem_rdid, i_wb_rdid, i_lng_rdid, i_lng_killid;
  logic i_ex_valid, i_ex_rdwen, i_ex_lden, i_mem_valid, i_mem_rdwen, i_mem_lden;
  logic i_wb_valid, i_wb_ready, i_wb_rdwen, i_lng_wen, i_lng_kill, i_ex_ldstbp, i_cnt_clr;
  logic [XLEN-1:0] i_ex_res, i_mem_exres, i_mem_lsres, i_wb_rd, i_lng_rd, i_ex_rs2;
  logic [NRD*XLEN-1:0] o_rs;
  logic o_ldstbp, o_stall;
  logic [XLEN-1:0] o_ex_rs2;
  logic [NREG-1:0] o_sb_pend;
  logic [CNTW-1:0] o_ldu_cnt, o_sb_cnt;

  int pass_cnt = 0, tot_cnt = 0;
  logic [63:0] m_rf [32];
  logic [31:0] m_pend;
  int m_ldu, m_sb;

  bypass_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .CNTW(CNTW)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(i_flush), .i_rsid(i_rsid), .i_rsren(i_rsren),
    .i_idu_rdid(i_idu_rdid), .i_idu_rdwen(i_idu_rdwen), .i_idu_sten(i_idu_sten), .i_idu_lng(i_idu_lng),
    .i_ex_valid(i_ex_valid), .i_ex_rdwen(i_ex_rdwen), .i_ex_lden(i_ex_lden), .i_ex_rdid(i_ex_rdid),
    .i_ex_res(i_ex_res), .i_mem_valid(i_mem_valid), .i_mem_rdwen(i_mem_rdwen), .i_mem_lden(i_mem_lden),
    .i_mem_rdid(i_mem_rdid), .i_mem_exres(i_mem_exres), .i_mem_lsres(i_mem_lsres),
    .i_wb_valid(i_wb_valid), .i_wb_ready(i_wb_ready), .i_wb_rdwen(i_wb_rdwen), .i_wb_rdid(i_wb_rdid),
    .i_wb_rd(i_wb_rd), .i_lng_wen(i_lng_wen), .i_lng_rdid(i_lng_rdid), .i_lng_rd(i_lng_rd),
    .i_lng_kill(i_lng_kill), .i_lng_killid(i_lng_killid), .i_ex_ldstbp(i_ex_ldstbp), .i_ex_rs2(i_ex_rs2),
    .i_cnt_clr(i_cnt_clr), .o_rs(o_rs), .o_ldstbp(o_ldstbp), .o_ex_rs2(o_ex_rs2), .o_stall(o_stall),
    .o_sb_pend(o_sb_pend), .o_ldu_cnt(o_ldu_cnt), .o_sb_cnt(o_sb_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst)
      assert (!(i_wb_rdwen && i_wb_valid && i_wb_ready && !i_flush && i_lng_wen &&
                i_wb_rdid == i_lng_rdid && i_wb_rdid != 0))
      else $error("FAIL dual_write: both ports wrote index %0d", i_wb_rdid);

  typedef struct {
    logic exv; logic [4:0] exid; logic memv; logic memld; logic [4:0] memid;
    logic wbv; logic [4:0] wbid; logic [4:0] rs; logic [63:0] exp;
  } fv_t;
  fv_t tv [7];

  function automatic fv_t mk(int exv, int exid, int memv, int memld, int memid,
                             int wbv, int wbid, int rs, logic [63:0] e);
    mk.exv = 1'(exv); mk.exid = 5'(exid); mk.memv = 1'(memv); mk.memld = 1'(memld);
    mk.memid = 5'(memid); mk.wbv = 1'(wbv); mk.wbid = 5'(wbid); mk.rs = 5'(rs); mk.exp = e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [63:0] rsv(input int k);
    return o_rs[k*XLEN +: XLEN];
  endfunction

  task automatic idle();
    i_flush = 0; i_rsid = '0; i_rsren = '0; i_idu_rdid = '0; i_idu_rdwen = 0; i_idu_sten = 0;
    i_idu_lng = 0; i_ex_valid = 0; i_ex_rdwen = 0; i_ex_lden = 0; i_ex_rdid = '0; i_ex_res = '0;
    i_mem_valid = 0; i_mem_rdwen = 0; i_mem_lden = 0; i_mem_rdid = '0; i_mem_exres = '0;
    i_mem_lsres = '0; i_wb_valid = 0; i_wb_ready = 0; i_wb_rdwen = 0; i_wb_rdid = '0; i_wb_rd = '0;
    i_lng_wen = 0; i_lng_rdid = '0; i_lng_rd = '0; i_lng_kill = 0; i_lng_killid = '0;
    i_ex_ldstbp = 0; i_ex_rs2 = '0; i_cnt_clr = 0;
  endtask

  task automatic rnd();
    i_flush = ($urandom_range(7) == 0);
    i_rsid = {5'($urandom_range(7)), 5'($urandom_range(7))};
    i_rsren = 2'($urandom);
    i_idu_rdid = 5'($urandom_range(7)); i_idu_rdwen = 1'($urandom); i_idu_sten = 1'($urandom);
    i_idu_lng = ($urandom_range(3) == 0);
    i_ex_valid = 1'($urandom); i_ex_rdwen = 1'($urandom); i_ex_lden = 1'($urandom);
    i_ex_rdid = 5'($urandom_range(7)); i_ex_res = {$urandom, $urandom};
    i_mem_valid = 1'($urandom); i_mem_rdwen = 1'($urandom); i_mem_lden = 1'($urandom);
    i_mem_rdid = 5'($urandom_range(7)); i_mem_exres = {$urandom, $urandom};
    i_mem_lsres = {$urandom, $urandom};
    i_wb_valid = 1'($urandom); i_wb_ready = 1'($urandom); i_wb_rdwen = 1'($urandom);
    i_wb_rdid = 5'($urandom_range(7)); i_wb_rd = {$urandom, $urandom};
    i_lng_wen = ($urandom_range(3) == 0); i_lng_rdid = 5'($urandom_range(7));
    i_lng_rd = {$urandom, $urandom};
    i_lng_kill = ($urandom_range(7) == 0); i_lng_killid = 5'($urandom_range(7));
    i_ex_ldstbp = 1'($urandom); i_ex_rs2 = {$urandom, $urandom};
    i_cnt_clr = ($urandom_range(31) == 0);
    if (i_wb_rdwen && i_wb_valid && i_wb_ready && !i_flush && i_lng_wen &&
        i_wb_rdid == i_lng_rdid && i_wb_rdid != 0)
      i_lng_rdid = i_lng_rdid ^ 5'd1;
  endtask

  function automatic logic [63:0] m_fwd(input logic [4:0] id);
    if (id == 0) return 0;
    if (i_ex_valid && i_ex_rdwen && !i_ex_lden && i_ex_rdid == id) return i_ex_res;
    if (i_mem_valid && i_mem_rdwen && i_mem_rdid == id) return i_mem_lden ? i_mem_lsres : i_mem_exres;
    if (i_lng_wen && i_lng_rdid == id) return i_lng_rd;
    if (i_wb_valid && i_wb_rdwen && i_wb_rdid == id) return i_wb_rd;
    return m_rf[id];
  endfunction

  task automatic model_cycle();
    logic [31:0] pe;
    logic [4:0] r0, r1;
    logic ldex, m0, m1, ldu, sbs, stall;
    r0 = i_rsid[4:0]; r1 = i_rsid[9:5];
    pe = m_pend;
    if (i_lng_wen) pe[i_lng_rdid] = 1'b0;
    if (i_lng_kill) pe[i_lng_killid] = 1'b0;
    ldex = i_ex_valid && i_ex_lden && i_ex_rdwen && i_ex_rdid != 0;
    m0 = i_rsren[0] && r0 == i_ex_rdid;
    m1 = i_rsren[1] && r1 == i_ex_rdid;
    ldu = ldex && (m0 || (m1 && !i_idu_sten));
    sbs = (i_rsren[0] && pe[r0]) || (i_rsren[1] && pe[r1]) || (i_idu_rdwen && pe[i_idu_rdid]);
    stall = ldu || sbs;
    chk("rnd_rs0", rsv(0), m_fwd(r0));
    chk("rnd_rs1", rsv(1), m_fwd(r1));
    chk("rnd_stall", 64'(o_stall), 64'(stall));
    chk("rnd_ldstbp", 64'(o_ldstbp), 64'(ldex && i_idu_sten && m1 && !m0));
    chk("rnd_ex_rs2", o_ex_rs2, i_ex_ldstbp ? m_fwd(r1) : i_ex_rs2);
    @(posedge clk);
    if (i_wb_rdwen && i_wb_valid && i_wb_ready && !i_flush && i_wb_rdid != 0) m_rf[i_wb_rdid] = i_wb_rd;
    if (i_lng_wen && i_lng_rdid != 0) m_rf[i_lng_rdid] = i_lng_rd;
    m_pend = pe;
    if (i_idu_lng && i_idu_rdwen && !stall && i_idu_rdid != 0) m_pend[i_idu_rdid] = 1'b1;
    m_ldu = i_cnt_clr ? 0 : m_ldu + ((ldu && m_ldu < CMAX) ? 1 : 0);
    m_sb  = i_cnt_clr ? 0 : m_sb + ((sbs && !ldu && m_sb < CMAX) ? 1 : 0);
    @(negedge clk);
    chk("rnd_pend", 64'(o_sb_pend), 64'(m_pend));
    chk("rnd_ldu_cnt", 64'(o_ldu_cnt), 64'(m_ldu));
    chk("rnd_sb_cnt", 64'(o_sb_cnt), 64'(m_sb));
  endtask

  initial begin
    idle();
    tv[0] = mk(1, 3, 1, 0, 3, 1, 3, 3, 64'hA);
    tv[1] = mk(0, 3, 1, 0, 3, 1, 3, 3, 64'hB);
    tv[2] = mk(0, 3, 0, 0, 3, 1, 3, 3, 64'hC);
    tv[3] = mk(1, 0, 1, 0, 0, 1, 0, 3, 64'h0);
    tv[4] = mk(0, 3, 1, 1, 3, 1, 3, 3, 64'hD);
    tv[5] = mk(1, 4, 1, 0, 3, 1, 3, 3, 64'hB);
    tv[6] = mk(1, 3, 1, 0, 3, 1, 3, 0, 64'h0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_pend", 64'(o_sb_pend), 0);
    chk("reset_ldu_cnt", 64'(o_ldu_cnt), 0);
    chk("reset_sb_cnt", 64'(o_sb_cnt), 0);
    chk("reset_stall", 64'(o_stall), 0);

    for (int i = 0; i < 7; i++) begin
      idle();
      i_ex_valid = tv[i].exv; i_ex_rdwen = 1; i_ex_rdid = tv[i].exid; i_ex_res = 64'hA;
      i_mem_valid = tv[i].memv; i_mem_rdwen = 1; i_mem_lden = tv[i].memld; i_mem_rdid = tv[i].memid;
      i_mem_exres = 64'hB; i_mem_lsres = 64'hD;
      i_wb_valid = tv[i].wbv; i_wb_rdwen = 1; i_wb_rdid = tv[i].wbid; i_wb_rd = 64'hC;
      i_rsid = {5'd0, tv[i].rs}; i_rsren = 2'b01;
      #1 chk($sformatf("fwd_vec%0d", i), rsv(0), tv[i].exp);
    end
    idle();
    @(negedge clk);

    i_wb_valid = 1; i_wb_ready = 1; i_wb_rdwen = 1; i_wb_rdid = 5; i_wb_rd = 64'h11;
    i_rsid = {5'd0, 5'd5}; i_rsren = 2'b01;
    #1 chk("wb_same_cycle_fwd", rsv(0), 64'h11);
    @(negedge clk);
    idle(); i_rsid = {5'd0, 5'd5}; i_rsren = 2'b01;
    #1 chk("wb_regfile_read", rsv(0), 64'h11);
    @(negedge clk);

    idle();
    i_ex_valid = 1; i_ex_lden = 1; i_ex_rdwen = 1; i_ex_rdid = 7;
    i_rsid = {5'd0, 5'd7}; i_rsren = 2'b01; i_idu_rdwen = 1; i_idu_rdid = 8;
    #1 chk("ldu_stall", 64'(o_stall), 1);
    chk("ldu_no_ldstbp", 64'(o_ldstbp), 0);
    @(negedge clk);
    chk("ldu_cnt_1", 64'(o_ldu_cnt), 1);
    i_idu_sten = 1; i_rsid = {5'd7, 5'd2}; i_rsren = 2'b11; i_ex_rs2 = 64'h99;
    #1 chk("store_no_stall", 64'(o_stall), 0);
    chk("store_ldstbp", 64'(o_ldstbp), 1);
    chk("ex_rs2_pass", o_ex_rs2, 64'h99);
    @(negedge clk);
    chk("ldu_cnt_store_hold", 64'(o_ldu_cnt), 1);

    idle(); i_idu_lng = 1; i_idu_rdwen = 1; i_idu_rdid = 9;
    #1 chk("lng_issue_no_stall", 64'(o_stall), 0);
    @(negedge clk);
    idle();
    chk("sb_pend9", 64'(o_sb_pend), 64'h200);
    i_rsid = {5'd9, 5'd0}; i_rsren = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("sb_stall_c%0d", i), 64'(o_stall), 1);
      @(negedge clk);
    end
    i_lng_wen = 1; i_lng_rdid = 9; i_lng_rd = 64'h55;
    #1 chk("lng_wb_fwd", rsv(1), 64'h55);
    chk("lng_wb_no_stall", 64'(o_stall), 0);
    @(negedge clk);
    idle(); i_rsid = {5'd9, 5'd0};
    chk("sb_pend_clear", 64'(o_sb_pend), 0);
    chk("sb_cnt_4", 64'(o_sb_cnt), 4);
    #1 chk("lng_regfile", rsv(1), 64'h55);
    @(negedge clk);

    idle(); i_idu_lng = 1; i_idu_rdwen = 1; i_idu_rdid = 9;
    @(negedge clk);
    chk("kill_pre_pend", 64'(o_sb_pend), 64'h200);
    i_lng_kill = 1; i_lng_killid = 9;
    #1 chk("kill_reissue_no_stall", 64'(o_stall), 0);
    @(negedge clk);
    chk("kill_set_wins", 64'(o_sb_pend), 64'h200);
    idle(); i_idu_rdwen = 1; i_idu_rdid = 9;
    #1 chk("waw_stall", 64'(o_stall), 1);
    @(negedge clk);
    chk("sb_cnt_5", 64'(o_sb_cnt), 5);
    idle(); i_rsid = {5'd0, 5'd5};
    #2 rst = 1;
    #1 chk("async_rst_pend", 64'(o_sb_pend), 0);
    chk("async_rst_ldu_cnt", 64'(o_ldu_cnt), 0);
    chk("async_rst_sb_cnt", 64'(o_sb_cnt), 0);
    chk("async_rst_regfile", rsv(0), 0);
    rst = 0;
    @(negedge clk);

    idle(); i_idu_lng = 1; i_idu_rdwen = 1; i_idu_rdid = 9;
    @(negedge clk);
    idle(); i_rsid = {5'd9, 5'd0}; i_rsren = 2'b10;
    repeat (18) @(negedge clk);
    chk("sb_cnt_saturate", 64'(o_sb_cnt), CMAX);
    chk("ldu_cnt_unchanged", 64'(o_ldu_cnt), 0);
    i_cnt_clr = 1;
    @(negedge clk);
    chk("cnt_clr_priority", 64'(o_sb_cnt), 0);
    i_cnt_clr = 0;
    @(negedge clk);
    chk("cnt_after_clr", 64'(o_sb_cnt), 1);
    idle(); i_lng_kill = 1; i_lng_killid = 9;
    @(negedge clk);
    chk("kill_clears", 64'(o_sb_pend), 0);

    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pend = '0; m_ldu = 0; m_sb = 0;
    for (int n = 0; n < 3000; n++) begin
      rnd();
      #1 model_cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
